acc_channel_monitor: RTL and testbench

- Parametrised N-channel accelerometer sample monitor that drives the board LED bank from the accelerometer controller's per-axis outputs.
- Runs on the slow display clock clk_25 and selects one channel by priority.
- Presents that channel in one of four modes: raw, moving average, peak-magnitude hold, or thermometer bar graph.
- Sits between the accelerometer controller and the LED pins. It generalises the fixed 3-axis raw-value display.

---
 rtl/acc_channel_monitor.sv | 188 ++++++++++++++++++
 tb/tb_acc_channel_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/acc_channel_monitor.sv
// acc_channel_monitor: N-channel accelerometer sample monitor for the LED bank.
// Captures every channel each clk_25 cycle and keeps a moving average and a
// peak-magnitude hold per channel. It then shows the lowest selected channel
// as raw, average, peak or bar graph. Latency from input capture to LED is
// two edges in every mode.
module acc_channel_monitor #(
    parameter int unsigned NCH       = 3,
    parameter int unsigned W         = 12,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned LED_W     = 12,
    parameter int unsigned BAR_SHIFT = 7
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic [NCH*W-1:0]   acc_flat,
    input  logic [NCH-1:0]     sel,
    input  logic [1:0]         mode,
    input  logic               peak_clr,
    output logic [LED_W-1:0]   led,
    output logic               avg_valid
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SW    = W + AVG_LOG2;
    localparam int unsigned MW    = W - 1;
    localparam int unsigned FW    = AVG_LOG2 + 1;

    localparam logic [1:0] MODE_RAW  = 2'd0;
    localparam logic [1:0] MODE_AVG  = 2'd1;
    localparam logic [1:0] MODE_PEAK = 2'd2;
    localparam logic [1:0] MODE_BAR  = 2'd3;

    // Absolute value of a W-bit sample; the most negative code saturates.
    function automatic logic [MW-1:0] mag(input logic signed [W-1:0] v);
        logic signed [W-1:0] neg;
        neg = -v;
        if (v == {1'b1, {MW{1'b0}}}) begin
            return {MW{1'b1}};
        end else if (v[W-1]) begin
            return MW'(neg);
        end else begin
            return MW'(v);
        end
    endfunction

    logic signed [W-1:0]  cap   [NCH];
    logic signed [W-1:0]  raw_d [NCH];
    logic signed [W-1:0]  win   [NCH][DEPTH];
    logic signed [SW-1:0] sum   [NCH];
    logic signed [W-1:0]  avg   [NCH];
    logic [MW-1:0]        peak  [NCH];
    logic [AVG_LOG2-1:0]  ptr;
    logic [FW-1:0]        fill;
    logic                 cap_vld;

    // Stage 1: register every channel from the flat input bus.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cap[c] <= '0;
            end
            cap_vld <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cap[c] <= acc_flat[c*W +: W];
            end
            cap_vld <= 1'b1;
        end
    end

    // Stage 2: window buffers, running sums, peaks and the raw delay copy.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                raw_d[c] <= '0;
                sum[c]   <= '0;
                peak[c]  <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    win[c][d] <= '0;
                end
            end
            ptr <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                raw_d[c]    <= cap[c];
                sum[c]      <= sum[c] + SW'(cap[c]) - SW'(win[c][ptr]);
                win[c][ptr] <= cap[c];
                if (peak_clr) begin
                    peak[c] <= '0;
                end else if (mag(cap[c]) > peak[c]) begin
                    peak[c] <= mag(cap[c]);
                end
            end
            ptr <= ptr + 1'b1;
        end
    end

    // Fill counter: counts stage-2 updates of real samples; avg_valid is sticky.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            fill      <= '0;
            avg_valid <= 1'b0;
        end else if (cap_vld && (fill != FW'(DEPTH))) begin
            fill <= fill + 1'b1;
            if (fill == FW'(DEPTH - 1)) begin
                avg_valid <= 1'b1;
            end
        end
    end

    // Window average, arithmetic shift rounds toward minus infinity.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            avg[c] = W'(sum[c] >>> AVG_LOG2);
        end
    end

    logic signed [W-1:0] s_raw;
    logic signed [W-1:0] s_avg;
    logic [MW-1:0]       s_peak;
    logic [W-1:0]        s_peak_ext;

    // Priority select: the lowest set bit of sel wins.
    always_comb begin
        s_raw  = '0;
        s_avg  = '0;
        s_peak = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (sel[c]) begin
                s_raw  = raw_d[c];
                s_avg  = avg[c];
                s_peak = peak[c];
            end
        end
        s_peak_ext = {1'b0, s_peak};
    end

    logic [LED_W-1:0] fit_raw;
    logic [LED_W-1:0] fit_avg;
    logic [LED_W-1:0] fit_peak;

    // Fit W-bit values to the LED width: keep the top bits or extend.
    generate
        if (LED_W >= W) begin : g_extend
            always_comb begin
                fit_raw  = LED_W'(s_raw);
                fit_avg  = LED_W'(s_avg);
                fit_peak = LED_W'(s_peak_ext);
            end
        end else begin : g_truncate
            always_comb begin
                fit_raw  = s_raw[W-1 -: LED_W];
                fit_avg  = s_avg[W-1 -: LED_W];
                fit_peak = s_peak_ext[W-1 -: LED_W];
            end
        end
    endgenerate

    logic [MW-1:0]    bar_len;
    logic [LED_W-1:0] bar;

    // Thermometer code; lengths beyond LED_W light every LED.
    always_comb begin
        bar_len = mag(s_avg) >> BAR_SHIFT;
        bar     = '0;
        for (int i = 0; i < LED_W; i++) begin
            bar[i] = (32'(bar_len) > 32'(i));
        end
    end

    // Stage 3: register the displayed value; no selection shows all ones.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            led <= '1;
        end else if (sel == '0) begin
            led <= '1;
        end else begin
            case (mode)
                MODE_RAW:  led <= fit_raw;
                MODE_AVG:  led <= fit_avg;
                MODE_PEAK: led <= fit_peak;
                MODE_BAR:  led <= bar;
                default:   led <= '1;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_channel_monitor.sv
// Directed bench for acc_channel_monitor with the default 3 x 12-bit setup.
module tb_acc_channel_monitor;

    localparam int unsigned NCH   = 3;
    localparam int unsigned W     = 12;
    localparam int unsigned LED_W = 12;

    logic               clk_25 = 1'b0;
    logic               rst;
    logic [NCH*W-1:0]   acc_flat;
    logic [NCH-1:0]     sel;
    logic [1:0]         mode;
    logic               peak_clr;
    logic [LED_W-1:0]   led;
    logic               avg_valid;

    int checks = 0;
    int errors = 0;

    acc_channel_monitor #(
        .NCH(NCH), .W(W), .AVG_LOG2(2), .LED_W(LED_W), .BAR_SHIFT(7)
    ) dut (
        .clk_25   (clk_25),
        .rst      (rst),
        .acc_flat (acc_flat),
        .sel      (sel),
        .mode     (mode),
        .peak_clr (peak_clr),
        .led      (led),
        .avg_valid(avg_valid)
    );

    always #20 clk_25 = ~clk_25;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25);
            #1;
        end
    endtask

    task automatic set_x(input logic [W-1:0] v);
        acc_flat[W-1:0] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        acc_flat = '0;
        sel      = '0;
        mode     = 2'd0;
        peak_clr = 1'b0;
        #1;
        check("reset_led", 32'(led), 32'hFFF);
        check("reset_avg_valid", 32'(avg_valid), 32'h0);
        tick(2);
        check("reset_led_clk", 32'(led), 32'hFFF);
        rst = 1'b0;
        tick(3);
        check("sel0_led", 32'(led), 32'hFFF);

        // Raw mode, priority select y over z, then z alone.
        acc_flat = {12'h456, 12'h123, 12'h000};
        sel  = 3'b110;
        mode = 2'd0;
        tick(3);
        check("raw_y", 32'(led), 32'h123);
        sel = 3'b100;
        tick(1);
        check("raw_z", 32'(led), 32'h456);

        // Asynchronous reset mid-operation, then the averaging step response.
        acc_flat = '0;
        set_x(12'd400);
        sel  = 3'b001;
        mode = 2'd1;
        rst  = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'hFFF);
        check("async_rst_valid", 32'(avg_valid), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("valid_k", 32'(avg_valid), 32'h0);
        tick(2);
        check("avg_k2", 32'(led), 32'd100);
        check("valid_k2", 32'(avg_valid), 32'h0);
        tick(1);
        check("avg_k3", 32'(led), 32'd200);
        check("valid_k3", 32'(avg_valid), 32'h0);
        tick(1);
        check("avg_k4", 32'(led), 32'd300);
        check("valid_k4", 32'(avg_valid), 32'h1);
        tick(1);
        check("avg_k5", 32'(led), 32'd400);

        // Alternating -4/+2 averages to -1; most negative input does not overflow.
        for (int i = 0; i < 10; i++) begin
            set_x((i % 2 == 0) ? 12'hFFC : 12'h002);
            tick(1);
        end
        check("avg_alt_a", 32'(led), 32'hFFF);
        set_x(12'hFFC);
        tick(1);
        check("avg_alt_b", 32'(led), 32'hFFF);
        set_x(12'h800);
        tick(6);
        check("avg_min", 32'(led), 32'h800);

        // Peak hold: clear, then 100, -900, 300.
        set_x(12'h000);
        peak_clr = 1'b1;
        tick(1);
        peak_clr = 1'b0;
        mode = 2'd2;
        tick(1);
        set_x(12'd100);
        tick(1);
        set_x(12'hC7C);
        tick(1);
        set_x(12'd300);
        tick(1);
        check("peak_100", 32'(led), 32'd100);
        tick(1);
        check("peak_900", 32'(led), 32'd900);
        tick(3);
        check("peak_hold", 32'(led), 32'd900);
        set_x(12'h800);
        peak_clr = 1'b1;
        tick(1);
        peak_clr = 1'b0;
        tick(1);
        check("peak_clr", 32'(led), 32'h000);
        tick(1);
        check("peak_sat", 32'(led), 32'd2047);

        // Bar graph.
        mode = 2'd3;
        set_x(12'd1000);
        tick(6);
        check("bar_1000", 32'(led), 32'h07F);
        mode = 2'd1;
        tick(1);
        check("mode_switch_avg", 32'(led), 32'd1000);
        sel = 3'b000;
        tick(1);
        check("sel0_avg", 32'(led), 32'hFFF);
        sel  = 3'b001;
        mode = 2'd3;
        set_x(12'd127);
        tick(6);
        check("bar_127", 32'(led), 32'h000);
        set_x(12'h800);
        tick(6);
        check("bar_clip", 32'(led), 32'hFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
